hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock, single domain.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port: id_rs1, id_rs2  in  5 each  ID-stage source register indices.
REQ-004 SHALL have port: id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
REQ-005 SHALL have port: ex_rd  in  5  EX-stage destination index.
REQ-006 SHALL have port: ex_mem_read  in  1  EX instruction is a load.
REQ-007 SHALL have port: ex_branch_taken  in  1  taken branch/jump resolved in EX this cycle.
REQ-008 SHALL have port: fpu_start  in  1  multi-cycle FPU op enters EX this cycle.
REQ-009 SHALL have port: fpu_cycles  in  4  extra EX cycles the FPU op needs (0..15).
REQ-010 SHALL have port: pc_stall  out  1  hold PC.
REQ-011 SHALL have port: if_id_stall  out  1  hold IF/ID register (drives its stall input).
REQ-012 SHALL have port: if_id_flush  out  1  zero IF/ID register (drives its branch input).
REQ-013 SHALL have port: id_ex_bubble  out  1  insert NOP into ID/EX.
REQ-014 SHALL have port: fpu_busy  out  1  FPU wait in progress.
REQ-015 SHALL have port: stall_count  out  16  saturating count of cycles with if_id_stall=1.

Function
REQ-016 SHALL implement FSM states RUN, FPU_WAIT, FLUSH_SHADOW; encoding free.
REQ-017 SHALL hold a 4-bit down-counter fpu_cnt.
REQ-018 Load-use hazard SHALL be combinational: ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 Event priority (highest first) SHALL be: ex_branch_taken, FPU wait, load-use.
REQ-020 ex_branch_taken=1 (any state) SHALL give same cycle: if_id_flush=1, id_ex_bubble=1, if_id_stall=0, pc_stall=0.
REQ-021 ex_branch_taken=1 SHALL transition to FLUSH_SHADOW and clear fpu_cnt to 0 (FPU op squashed).
REQ-022 In FLUSH_SHADOW, load-use detection SHALL be suppressed (ID holds a bubble); next state RUN, unless ex_branch_taken=1 again, which stays in FLUSH_SHADOW.
REQ-023 In RUN, fpu_start=1 with fpu_cycles=N>0 SHALL load fpu_cnt=N and transition to FPU_WAIT; N=0 SHALL remain in RUN, no stall.
REQ-024 In FPU_WAIT: pc_stall=1, if_id_stall=1, id_ex_bubble=0, fpu_busy=1; fpu_cnt decrements each cycle; at fpu_cnt==1 the next state SHALL be RUN; exactly N stall cycles per op.
REQ-025 In FPU_WAIT, fpu_start SHALL be ignored.
REQ-026 Load-use in RUN (no branch, not entering FPU_WAIT) SHALL give pc_stall=1, if_id_stall=1, id_ex_bubble=1 for exactly that cycle; no state change.
REQ-027 fpu_start and load-use in the same RUN cycle: load-use stall SHALL assert that cycle and FPU_WAIT SHALL still be entered.
REQ-028 if_id_flush and if_id_stall SHALL never both be 1.
REQ-029 stall_count SHALL increment on each clk edge where if_id_stall=1 and saturate at 16'hFFFF.
REQ-030 ex_rd==0 SHALL never cause a load-use stall.

Reset
REQ-031 reset=1 SHALL force state=RUN, fpu_cnt=0, stall_count=0 asynchronously.
REQ-032 While reset=1, pc_stall, if_id_stall, if_id_flush, id_ex_bubble and fpu_busy SHALL all be 0.
REQ-033 reset asserted mid FPU_WAIT SHALL abort the wait; the first cycle after deassertion SHALL be RUN with no stall.

Verification
REQ-034 Bench SHALL check: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_stall=if_id_stall=id_ex_bubble=1; stall_count 0->1.
REQ-035 Bench SHALL check: same stimulus with ex_rd=0 -> no stall.
REQ-036 Bench SHALL check: fpu_start=1, fpu_cycles=3 -> fpu_busy=1 and if_id_stall=1 for exactly 3 cycles, then RUN; fpu_cycles=0 -> no stall.
REQ-037 Bench SHALL check: ex_branch_taken=1 during FPU_WAIT (fpu_cnt=2) -> if_id_flush=1, if_id_stall=0 that cycle; next cycle state FLUSH_SHADOW, fpu_busy=0.
REQ-038 Bench SHALL check: branch, then load-use pattern in the next cycle -> no stall (shadow suppression).
REQ-039 Bench SHALL check: async reset pulse between clk edges during FPU_WAIT -> outputs 0 immediately; stall_count=0; forced 16'hFFFF plus one stall cycle stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle FPU waits
// and taken-branch flushes, plus a saturating stall cycle counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        fpu_start,
    input  logic [3:0]  fpu_cycles,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        fpu_busy,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        FPU_WAIT     = 2'd1,
        FLUSH_SHADOW = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [3:0] fpu_cnt;
    logic [3:0] fpu_cnt_n;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            fpu_cnt <= 4'd0;
        end else begin
            state   <= state_n;
            fpu_cnt <= fpu_cnt_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (if_id_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    always_comb begin
        state_n      = state;
        fpu_cnt_n    = fpu_cnt;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        fpu_busy     = 1'b0;
        if (!reset) begin
            fpu_busy = (state == FPU_WAIT);
            if (ex_branch_taken) begin
                // The branch squashes any in-flight FPU wait
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_n      = FLUSH_SHADOW;
                fpu_cnt_n    = 4'd0;
            end else begin
                unique case (state)
                    FPU_WAIT: begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        fpu_cnt_n   = fpu_cnt - 4'd1;
                        if (fpu_cnt <= 4'd1) begin
                            state_n   = RUN;
                            fpu_cnt_n = 4'd0;
                        end
                    end
                    FLUSH_SHADOW: begin
                        state_n = RUN;
                    end
                    default: begin
                        if (load_use) begin
                            pc_stall     = 1'b1;
                            if_id_stall  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end
                        if (fpu_start && (fpu_cycles != 4'd0)) begin
                            state_n   = FPU_WAIT;
                            fpu_cnt_n = fpu_cycles;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle model compare plus
// hand-computed checks of the key hazard scenarios.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        fpu_start = 1'b0;
    logic [3:0]  fpu_cycles = '0;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        fpu_busy;
    logic [15:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    // model: 0 = running, 1 = waiting on FPU, 2 = branch shadow
    int m_mode = 0;
    int m_left = 0;
    int m_count = 0;

    hazard_ctrl dut (
        .clk(clk),
        .reset(reset),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .fpu_start(fpu_start),
        .fpu_cycles(fpu_cycles),
        .pc_stall(pc_stall),
        .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .fpu_busy(fpu_busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_lu();
        bit hit1, hit2;
        hit1 = id_use_rs1 && (id_rs1 == ex_rd);
        hit2 = id_use_rs2 && (id_rs2 == ex_rd);
        return ex_mem_read && (ex_rd != 0) && (hit1 || hit2);
    endfunction

    // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fpu_busy}
    function automatic logic [4:0] m_out();
        logic [4:0] o;
        o = 5'b0;
        if (reset) return o;
        o[0] = (m_mode == 1);
        if (ex_branch_taken) begin
            o[2] = 1'b1;
            o[1] = 1'b1;
        end else if (m_mode == 1) begin
            o[4] = 1'b1;
            o[3] = 1'b1;
        end else if (m_mode == 0 && m_lu()) begin
            o[4] = 1'b1;
            o[3] = 1'b1;
            o[1] = 1'b1;
        end
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [4:0] o;
        if (reset) begin
            m_mode  = 0;
            m_left  = 0;
            m_count = 0;
        end else begin
            o = m_out();
            if (o[3] && m_count < 65535) m_count = m_count + 1;
            if (ex_branch_taken) begin
                m_mode = 2;
                m_left = 0;
            end else if (m_mode == 1) begin
                m_left = m_left - 1;
                m_mode = (m_left > 0) ? 1 : 0;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else if (fpu_start && fpu_cycles != 0) begin
                m_mode = 1;
                m_left = int'(fpu_cycles);
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0]  act;
        logic [4:0]  exp;
        logic [15:0] cexp;
        act  = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fpu_busy};
        exp  = m_out();
        cexp = 16'(m_count);
        vectors = vectors + 1;
        if (act !== exp || stall_count !== cexp) begin
            miscompares = miscompares + 1;
            $display("FAIL model t=%0t: outs %b cnt %h, want %b cnt %h",
                     $time, act, stall_count, exp, cexp);
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rd, input logic mr,
                         input logic br, input logic fs,
                         input logic [3:0] fc);
        @(posedge clk);
        #1;
        id_rs1          = rs1;
        id_rs2          = 5'd9;
        id_use_rs1      = u1;
        id_use_rs2      = 1'b0;
        ex_rd           = rd;
        ex_mem_read     = mr;
        ex_branch_taken = br;
        fpu_start       = fs;
        fpu_cycles      = fc;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic ld_use(input logic [4:0] rd);
        drive(5'd5, 1'b1, rd, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        #1;
        chk("rst_cnt", stall_count, 16'h0);
        chk("rst_pc", {15'b0, pc_stall}, 16'h0);
        reset = 1'b0;

        // load-use on x5
        ld_use(5'd5);
        mid();
        chk("lu_stall", {13'b0, pc_stall, if_id_stall, id_ex_bubble},
            16'h7);
        idle();
        mid();
        chk("lu_cnt", stall_count, 16'h1);
        chk("lu_one", {15'b0, pc_stall}, 16'h0);

        // x0 never stalls
        ld_use(5'd0);
        mid();
        chk("x0_stall", {15'b0, pc_stall}, 16'h0);

        // 3-cycle FPU op
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd3);
        mid();
        chk("fpu_start_busy", {15'b0, fpu_busy}, 16'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            mid();
            chk("fpu_wait", {14'b0, fpu_busy, if_id_stall}, 16'h3);
        end
        idle();
        mid();
        chk("fpu_done", {14'b0, fpu_busy, if_id_stall}, 16'h0);
        chk("fpu_cnt", stall_count, 16'h4);

        // zero-cycle FPU op
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0);
        idle();
        mid();
        chk("fpu0", {14'b0, fpu_busy, pc_stall}, 16'h0);

        // branch while fpu_cnt == 2
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd4);
        idle();
        idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        mid();
        chk("br_wait", {14'b0, if_id_flush, if_id_stall}, 16'h2);
        ld_use(5'd5);
        mid();
        chk("br_shadow", {14'b0, fpu_busy, pc_stall}, 16'h0);

        // branch from RUN, then load-use is suppressed once
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        mid();
        chk("br_run", {14'b0, if_id_flush, id_ex_bubble}, 16'h3);
        ld_use(5'd5);
        mid();
        chk("shadow_lu", {15'b0, pc_stall}, 16'h0);
        ld_use(5'd5);
        mid();
        chk("after_shadow", {15'b0, pc_stall}, 16'h1);

        // async reset between edges mid FPU wait
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd5);
        idle();
        mid();
        chk("pre_rst_busy", {15'b0, fpu_busy}, 16'h1);
        reset = 1'b1;
        #1;
        chk("arst_outs", {11'b0, pc_stall, if_id_stall, if_id_flush,
                          id_ex_bubble, fpu_busy}, 16'h0);
        chk("arst_cnt", stall_count, 16'h0);
        reset = 1'b0;
        idle();
        mid();
        chk("post_rst", {14'b0, fpu_busy, pc_stall}, 16'h0);

        // saturation: continuous load-use stalls
        ld_use(5'd5);
        repeat (65535) @(posedge clk);
        mid();
        chk("sat_reach", stall_count, 16'hFFFF);
        @(posedge clk);
        mid();
        chk("sat_hold", stall_count, 16'hFFFF);

        idle();
        mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
